// File: rtl/key_dir_if.sv
// Scan-code event / direction bundle between a PS/2 decoder front end and key_dir_tracker.
interface key_dir_if #(
    parameter int unsigned NUM_KEYS = 4,
    parameter int unsigned CNT_W    = 8
);
    logic                valid;
    logic                makeBreak;
    logic [7:0]          outCode;
    logic                tick;
    logic [NUM_KEYS-1:0] held;
    logic [1:0]          dir;
    logic                dir_valid;
    logic                dir_change;
    logic [CNT_W-1:0]    press_count;

    modport master (
        output valid, makeBreak, outCode, tick,
        input  held, dir, dir_valid, dir_change, press_count
    );

    modport slave (
        input  valid, makeBreak, outCode, tick,
        output held, dir, dir_valid, dir_change, press_count
    );
endinterface

// File: rtl/key_dir_tracker.sv
// Tracks held keys and a tick-committed game direction with reverse rejection.
// Optional press counter is built only when KEY_PRESS_CNT_EN is defined.
module key_dir_tracker #(
    parameter int unsigned                NUM_KEYS  = 4,
    parameter logic [NUM_KEYS*8-1:0]      KEY_CODES = {8'h23, 8'h1B, 8'h1C, 8'h1D},
    parameter int unsigned                CNT_W     = 8
) (
    input logic      clk,
    input logic      reset,
    key_dir_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(NUM_KEYS);

    logic [NUM_KEYS-1:0] held_q, held_d;
    logic [1:0]          dir_q, dir_d;
    logic                dir_valid_q, dir_valid_d;
    logic                dir_change_q, dir_change_d;
    logic [1:0]          pend_q, pend_d;
    logic                pend_valid_q, pend_valid_d;

    logic                match_found;
    logic [IDX_W-1:0]    match_idx;
    logic                new_press;
    logic                commit;
    logic                dir_slot;
    logic                reverse;

    // Scan downwards so the lowest matching slot wins on duplicate codes.
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        for (int i = int'(NUM_KEYS) - 1; i >= 0; i--) begin
            if (bus.valid && (KEY_CODES[8*i +: 8] == bus.outCode)) begin
                match_found = 1'b1;
                match_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        commit       = bus.tick && pend_valid_q;
        dir_d        = commit ? pend_q : dir_q;
        dir_valid_d  = dir_valid_q | commit;
        dir_change_d = commit && (!dir_valid_q || (pend_q != dir_q));
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q & ~commit;
        held_d       = held_q;

        new_press = match_found && bus.makeBreak && !held_q[match_idx];
        dir_slot  = ((match_idx >> 2) == '0);
        // Reverse is judged against the direction as it stands after this edge.
        reverse   = dir_valid_d && (match_idx[1:0] == (dir_d ^ 2'b10));

        if (match_found) begin
            held_d[match_idx] = bus.makeBreak;
        end
        if (new_press && dir_slot && !reverse) begin
            pend_d       = match_idx[1:0];
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_q       <= '0;
            dir_q        <= 2'd0;
            dir_valid_q  <= 1'b0;
            dir_change_q <= 1'b0;
            pend_q       <= 2'd0;
            pend_valid_q <= 1'b0;
        end else begin
            held_q       <= held_d;
            dir_q        <= dir_d;
            dir_valid_q  <= dir_valid_d;
            dir_change_q <= dir_change_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
        end
    end

`ifdef KEY_PRESS_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else if (new_press && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.press_count = cnt_q;
`else
    assign bus.press_count = {CNT_W{1'b0}};
`endif

    assign bus.held       = held_q;
    assign bus.dir        = dir_q;
    assign bus.dir_valid  = dir_valid_q;
    assign bus.dir_change = dir_change_q;
endmodule

// File: tb/tb_key_dir_tracker.sv
// Self-checking bench for key_dir_tracker: directed scenarios plus a randomized run
// against a behavioural model of held keys, pending request and committed direction.
module tb_key_dir_tracker;
    localparam int NK = 6;
    localparam int CW = 3;
    localparam int CMAX = 7;
    localparam logic [NK*8-1:0] CODES = {8'h2A, 8'h1D, 8'h23, 8'h1B, 8'h1C, 8'h1D};
`ifdef KEY_PRESS_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    key_dir_if #(.NUM_KEYS(NK), .CNT_W(CW)) bus ();

    key_dir_tracker #(.NUM_KEYS(NK), .KEY_CODES(CODES), .CNT_W(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    logic [7:0] code_tab [NK];
    bit         m_held [NK];
    int         m_dir, m_pend, m_cnt;
    bit         m_dv, m_pv, m_chg;

    function automatic logic [NK-1:0] held_vec();
        logic [NK-1:0] v;
        for (int i = 0; i < NK; i++) v[i] = m_held[i];
        return v;
    endfunction

    function automatic int pc(int n);
        return CntEn ? n : 0;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < NK; i++) m_held[i] = 1'b0;
        m_dir = 0; m_pend = 0; m_cnt = 0;
        m_dv = 1'b0; m_pv = 1'b0; m_chg = 1'b0;
    endtask

    task automatic model_step(bit v, bit mb, logic [7:0] code, bit tk);
        bit commit;
        int idx, nd, np;
        bit ndv, npv;
        commit = tk && m_pv;
        m_chg  = commit && (!m_dv || m_pend != m_dir);
        nd  = commit ? m_pend : m_dir;
        ndv = m_dv || commit;
        npv = m_pv && !commit;
        np  = m_pend;
        idx = -1;
        if (v) begin
            for (int i = 0; i < NK; i++) if (idx < 0 && code_tab[i] == code) idx = i;
        end
        if (idx >= 0) begin
            if (mb && !m_held[idx]) begin
                m_held[idx] = 1'b1;
                if (CntEn && m_cnt < CMAX) m_cnt++;
                if (idx < 4 && !(ndv && idx == (nd + 2) % 4)) begin
                    np  = idx;
                    npv = 1'b1;
                end
            end else if (!mb) begin
                m_held[idx] = 1'b0;
            end
        end
        m_dir = nd; m_dv = ndv; m_pv = npv; m_pend = np;
    endtask

    // Drive one cycle of inputs, advance the model on the edge, sample 1 time unit later.
    task automatic step(bit v, bit mb, logic [7:0] code, bit tk);
        @(negedge clk);
        bus.valid = v; bus.makeBreak = mb; bus.outCode = code; bus.tick = tk;
        @(posedge clk);
        model_step(v, mb, code, tk);
        #1;
        bus.valid = 1'b0; bus.tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        #2 reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_clear();
        #3;
        n_tests++; if (bus.held !== '0) begin n_fail++; $display("FAIL reset_held got %b want 0", bus.held); end
        n_tests++; if (bus.dir !== 2'd0) begin n_fail++; $display("FAIL reset_dir got %0d want 0", bus.dir); end
        n_tests++; if (bus.dir_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dv got %b want 0", bus.dir_valid); end
        n_tests++; if (bus.dir_change !== 1'b0) begin n_fail++; $display("FAIL reset_chg got %b want 0", bus.dir_change); end
        n_tests++; if (bus.press_count !== '0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", bus.press_count); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_first_dir();
        do_reset();
        step(1, 1, 8'h1D, 0);
        n_tests++; if (bus.held !== 6'b000001) begin n_fail++; $display("FAIL first_held got %b want 000001", bus.held); end
        n_tests++; if (bus.dir_valid !== 1'b0) begin n_fail++; $display("FAIL first_dv_early got %b want 0", bus.dir_valid); end
        n_tests++; if (int'(bus.press_count) != pc(1)) begin n_fail++; $display("FAIL first_cnt got %0d want %0d", bus.press_count, pc(1)); end
        step(0, 0, 8'h00, 1);
        n_tests++; if (bus.dir !== 2'd0 || bus.dir_valid !== 1'b1) begin n_fail++; $display("FAIL first_dir got %0d/%b want 0/1", bus.dir, bus.dir_valid); end
        n_tests++; if (bus.dir_change !== 1'b1) begin n_fail++; $display("FAIL first_chg got %b want 1", bus.dir_change); end
        step(0, 0, 8'h00, 0);
        n_tests++; if (bus.dir_change !== 1'b0) begin n_fail++; $display("FAIL first_chg_pulse got %b want 0", bus.dir_change); end
        step(0, 0, 8'h00, 1);
        n_tests++; if (bus.dir_change !== 1'b0) begin n_fail++; $display("FAIL idle_tick_chg got %b want 0", bus.dir_change); end
    endtask

    task automatic test_reverse();
        step(1, 1, 8'h1B, 0);
        n_tests++; if (int'(bus.press_count) != pc(2)) begin n_fail++; $display("FAIL rev_cnt got %0d want %0d", bus.press_count, pc(2)); end
        step(0, 0, 8'h00, 1);
        n_tests++; if (bus.dir !== 2'd0 || bus.dir_change !== 1'b0) begin n_fail++; $display("FAIL rev_dir got %0d/%b want 0/0", bus.dir, bus.dir_change); end
        n_tests++; if (bus.held !== 6'b000101) begin n_fail++; $display("FAIL rev_held got %b want 000101", bus.held); end
    endtask

    task automatic test_typematic();
        do_reset();
        step(1, 1, 8'h1C, 0);
        for (int k = 0; k < 5; k++) step(1, 1, 8'h1C, 0);
        n_tests++; if (bus.held !== 6'b000010) begin n_fail++; $display("FAIL typ_held got %b want 000010", bus.held); end
        n_tests++; if (int'(bus.press_count) != pc(1)) begin n_fail++; $display("FAIL typ_cnt got %0d want %0d", bus.press_count, pc(1)); end
        step(1, 0, 8'h1C, 0);
        n_tests++; if (bus.held !== 6'b000000) begin n_fail++; $display("FAIL typ_break got %b want 000000", bus.held); end
        step(0, 0, 8'h00, 1);
        n_tests++; if (bus.dir !== 2'd1 || bus.dir_change !== 1'b1) begin n_fail++; $display("FAIL typ_dir got %0d/%b want 1/1", bus.dir, bus.dir_change); end
    endtask

    task automatic test_last_wins();
        do_reset();
        step(1, 1, 8'h1D, 0);
        step(0, 0, 8'h00, 1);
        step(1, 1, 8'h1C, 0);
        step(1, 1, 8'h23, 0);
        step(0, 0, 8'h00, 1);
        n_tests++; if (bus.dir !== 2'd3 || bus.dir_change !== 1'b1) begin n_fail++; $display("FAIL last_wins got %0d/%b want 3/1", bus.dir, bus.dir_change); end
    endtask

    task automatic test_tick_collision();
        do_reset();
        step(1, 1, 8'h1D, 0);
        step(0, 0, 8'h00, 1);
        step(1, 1, 8'h1C, 0);
        step(1, 1, 8'h23, 1);
        n_tests++; if (bus.dir !== 2'd1 || bus.dir_change !== 1'b1) begin n_fail++; $display("FAIL coll_commit got %0d/%b want 1/1", bus.dir, bus.dir_change); end
        step(0, 0, 8'h00, 1);
        n_tests++; if (bus.dir !== 2'd1 || bus.dir_change !== 1'b0) begin n_fail++; $display("FAIL coll_reject got %0d/%b want 1/0", bus.dir, bus.dir_change); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step(1, 1, 8'h2A, 0);
            step(1, 0, 8'h2A, 0);
        end
        step(0, 0, 8'h00, 1);
        n_tests++; if (int'(bus.press_count) != pc(CMAX)) begin n_fail++; $display("FAIL sat_cnt got %0d want %0d", bus.press_count, pc(CMAX)); end
        n_tests++; if (bus.dir_valid !== 1'b0) begin n_fail++; $display("FAIL sat_nodir got %b want 0", bus.dir_valid); end
    endtask

    task automatic test_async_reset();
        do_reset();
        step(1, 1, 8'h1D, 0);
        step(0, 0, 8'h00, 1);
        step(1, 1, 8'h1C, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        model_clear();
        #1;
        n_tests++;
        if ({bus.held, bus.dir, bus.dir_valid, bus.dir_change, bus.press_count} !== '0) begin
            n_fail++;
            $display("FAIL async_reset got held=%b dir=%0d dv=%b chg=%b cnt=%0d want all 0",
                     bus.held, bus.dir, bus.dir_valid, bus.dir_change, bus.press_count);
        end
        #1 reset = 1'b1;
        step(0, 0, 8'h00, 1);
        n_tests++; if (bus.dir_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pend_drop got %b want 0", bus.dir_valid); end
        step(1, 1, 8'h1D, 0);
        n_tests++; if (bus.held !== 6'b000001 || int'(bus.press_count) != pc(1)) begin n_fail++; $display("FAIL rst_newpress got %b/%0d want 000001/%0d", bus.held, bus.press_count, pc(1)); end
    endtask

    task automatic test_random();
        logic [NK+CW+3:0] exp_v, got_v;
        bit v, mb, tk;
        logic [7:0] code;
        int sel, errs;
        errs = 0;
        for (int k = 0; k < 600; k++) begin
            v    = ($urandom_range(0, 3) != 0);
            mb   = ($urandom_range(0, 2) != 0);
            tk   = ($urandom_range(0, 3) == 0);
            sel  = $urandom_range(0, NK);
            code = (sel < NK) ? code_tab[sel] : 8'($urandom);
            step(v, mb, code, tk);
            exp_v = {held_vec(), 2'(m_dir), m_dv, m_chg, CW'(m_cnt)};
            got_v = {bus.held, bus.dir, bus.dir_valid, bus.dir_change, bus.press_count};
            n_tests++;
            if (got_v !== exp_v) begin
                n_fail++;
                errs++;
                if (errs <= 10) $display("FAIL random[%0d] got %b want %b", k, got_v, exp_v);
            end
        end
    endtask

    initial begin
        logic [NK*8-1:0] codes_v;
        codes_v = CODES;
        for (int i = 0; i < NK; i++) code_tab[i] = codes_v[8*i +: 8];
        bus.valid = 1'b0; bus.makeBreak = 1'b0; bus.outCode = 8'h00; bus.tick = 1'b0;
        test_reset();
        test_first_dir();
        test_reverse();
        test_typematic();
        test_last_wins();
        test_tick_collision();
        test_saturation();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
